// File: rtl/inv_buf_pkg.sv
// Shared types and helpers for the inverse-column buffer.
//   cplx_t   : one complex element, {im, re}, re in the low half.
//   state_t  : buffer controller states.
//   n_elems  : number of elements streamed for a given size / triangular mode.
package inv_buf_pkg;

  localparam int CPLX_W = 64;

  typedef struct packed {
    logic [CPLX_W-1:0] im;
    logic [CPLX_W-1:0] re;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  function automatic int n_elems(input int size, input bit skip_lower);
    return skip_lower ? (size * (size + 1)) / 2 : size * size;
  endfunction

endpackage

// File: rtl/inv_col_buffer_drain_ctr.sv
// Row/column index walker used while draining the buffer.
//   clk_i, rst_i : clock, async active-high reset
//   clear        : force indices back to (0,0)
//   advance      : step to the next element (one accepted beat)
//   row, col     : current element indices
//   last         : current element is (SIZE-1, SIZE-1)
// Row-major walk; in triangular mode each new row restarts on the diagonal.
module inv_drain_ctr #(
  parameter int SIZE       = 16,
  parameter bit SKIP_LOWER = 1'b0,
  parameter int AW         = $clog2(SIZE)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear,
  input  logic          advance,
  output logic [AW-1:0] row,
  output logic [AW-1:0] col,
  output logic          last
);

  localparam logic [AW-1:0] MAX_IDX = AW'(SIZE - 1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == MAX_IDX) begin
        row <= row + 1'b1;
        // Next row starts at the diagonal when only the upper triangle is kept.
        col <= SKIP_LOWER ? row + 1'b1 : '0;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == MAX_IDX) && (col == MAX_IDX);

endmodule

// File: rtl/inv_col_buffer.sv
// Collects complex inverse columns (any order, tagged by column index), then
// streams the full matrix out one element per beat in row-major order.
//   clk_i, rst_i          : clock, async active-high reset
//   start_i, flush_i      : begin a new collection / abort to idle
//   inv_col_i             : one column, element k at [k*2*WIDTH +: 2*WIDTH] = {im, re}
//   inv_col_addr_i        : column index of inv_col_i
//   inv_col_valid_i       : column present this cycle
//   out_ready_o           : buffer accepts columns (back-pressure to the inverter)
//   elem_o/row/col/valid  : output element stream, elem_ready_i from consumer
//   elem_last_o           : final element of the matrix
//   done_o                : one-cycle pulse after the final element is accepted
//   busy_o, err_o         : not idle / sticky duplicate or bad-address flag
//
// state   | meaning
// IDLE    | waiting for start_i, columns ignored
// COLLECT | accepting columns until every index has been seen once
// DRAIN   | streaming stored elements to the consumer
module inv_col_buffer
  import inv_buf_pkg::*;
#(
  parameter int SIZE       = 16,
  parameter int WIDTH      = 64,
  parameter bit SKIP_LOWER = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      flush_i,
  input  logic [SIZE*2*WIDTH-1:0]   inv_col_i,
  input  logic [$clog2(SIZE)-1:0]   inv_col_addr_i,
  input  logic                      inv_col_valid_i,
  output logic                      out_ready_o,
  output logic [2*WIDTH-1:0]        elem_o,
  output logic [$clog2(SIZE)-1:0]   elem_row_o,
  output logic [$clog2(SIZE)-1:0]   elem_col_o,
  output logic                      elem_valid_o,
  input  logic                      elem_ready_i,
  output logic                      elem_last_o,
  output logic                      done_o,
  output logic                      busy_o,
  output logic                      err_o
);

  localparam int AW = $clog2(SIZE);
  localparam int EW = 2 * WIDTH;
  localparam int CW = $clog2(SIZE + 1);

  state_t state_q, state_d;
  logic [SIZE-1:0]   bitmap_q;
  logic [CW-1:0]     count_q;
  logic              err_q;
  logic              done_q;
  logic [SIZE*EW-1:0] mem_q [SIZE];

  logic          in_range, dup, col_acc, wr_en, new_col, count_full;
  logic          fire;
  logic [AW-1:0] drain_row, drain_col;
  logic          drain_last;
  logic [SIZE*EW-1:0] sel_col;

  assign in_range   = int'(inv_col_addr_i) < SIZE;
  assign col_acc    = (state_q == COLLECT) && inv_col_valid_i && !start_i && !flush_i;
  assign dup        = in_range && bitmap_q[inv_col_addr_i];
  assign wr_en      = col_acc && in_range;
  assign new_col    = wr_en && !dup;
  assign count_full = new_col && (count_q == CW'(SIZE - 1));
  assign fire       = elem_valid_o && elem_ready_i;

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i) state_d = COLLECT;
        COLLECT: if (count_full) state_d = DRAIN;
        DRAIN:   if (fire && drain_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      bitmap_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= !flush_i && (state_q == DRAIN) && fire && drain_last;
      if (flush_i) begin
        bitmap_q <= '0;
        count_q  <= '0;
      end else if (start_i && (state_q != DRAIN)) begin
        bitmap_q <= '0;
        count_q  <= '0;
        err_q    <= 1'b0;
      end else if (col_acc) begin
        if (new_col) begin
          bitmap_q[inv_col_addr_i] <= 1'b1;
          count_q                  <= count_q + 1'b1;
        end
        if (!in_range || dup) err_q <= 1'b1;
      end
    end
  end

  // Column storage carries no reset; contents are only read after a full collection.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[inv_col_addr_i] <= inv_col_i;
  end

  inv_drain_ctr #(
    .SIZE       (SIZE),
    .SKIP_LOWER (SKIP_LOWER),
    .AW         (AW)
  ) u_drain_ctr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (state_q != DRAIN),
    .advance (fire),
    .row     (drain_row),
    .col     (drain_col),
    .last    (drain_last)
  );

  assign sel_col      = mem_q[drain_col];
  assign out_ready_o  = (state_q == COLLECT);
  assign elem_valid_o = (state_q == DRAIN);
  assign busy_o       = (state_q != IDLE);
  // Element fields are forced to zero outside DRAIN so idle outputs are clean.
  assign elem_o       = elem_valid_o ? sel_col[drain_row*EW +: EW] : '0;
  assign elem_row_o   = elem_valid_o ? drain_row : '0;
  assign elem_col_o   = elem_valid_o ? drain_col : '0;
  assign elem_last_o  = elem_valid_o && drain_last;
  assign done_o       = done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_inv_col_buffer.sv
module tb_inv_col_buffer;
  import inv_buf_pkg::*;

  localparam int SZ = 4;
  localparam int W  = 64;
  localparam int EW = 2 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst[2], start[2], flush[2], col_valid[2], ready[2];
  logic [SZ*EW-1:0] col_in[2];
  logic [1:0]      addr[2], row[2], col[2];
  logic            out_ready[2], valid[2], last[2], done[2], busy[2], err[2];
  logic [EW-1:0]   elem[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    inv_col_buffer #(.SIZE(SZ), .WIDTH(W), .SKIP_LOWER(g == 1)) u_dut (
      .clk_i           (clk),
      .rst_i           (rst[g]),
      .start_i         (start[g]),
      .flush_i         (flush[g]),
      .inv_col_i       (col_in[g]),
      .inv_col_addr_i  (addr[g]),
      .inv_col_valid_i (col_valid[g]),
      .out_ready_o     (out_ready[g]),
      .elem_o          (elem[g]),
      .elem_row_o      (row[g]),
      .elem_col_o      (col[g]),
      .elem_valid_o    (valid[g]),
      .elem_ready_i    (ready[g]),
      .elem_last_o     (last[g]),
      .done_o          (done[g]),
      .busy_o          (busy[g]),
      .err_o           (err[g])
    );
  end

  typedef struct {
    int            r;
    int            c;
    logic [EW-1:0] data;
    bit            last;
  } exp_t;

  exp_t          expq[2][$];
  logic [EW-1:0] mat[2][SZ][SZ];   // [dut][column][row]
  int            total, bad;
  int            beats[2], done_cnt[2];
  bit            pend_done[2], hold_v[2];
  logic [EW+3:0] hold_val[2];
  exp_t          e;

  task automatic check(input string name, input bit ok, input logic [159:0] act,
                       input logic [159:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops expected beats whenever an element is accepted.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pend_done[d]) begin
        check("done_pulse", done[d] === 1'b1, 160'(done[d]), 160'(1));
        if (done[d] === 1'b1) done_cnt[d]++;
        pend_done[d] = 0;
      end else if (done[d] !== 1'b0) begin
        check("done_unexpected", 1'b0, 160'(done[d]), 160'(0));
      end
      if (hold_v[d] && valid[d])
        check("stall_hold", {elem[d], row[d], col[d]} == hold_val[d],
              160'({elem[d], row[d], col[d]}), 160'(hold_val[d]));
      hold_v[d]   = valid[d] && !ready[d];
      hold_val[d] = {elem[d], row[d], col[d]};
      if (valid[d] && ready[d]) begin
        beats[d]++;
        if (d == 1) check("upper_tri", row[d] <= col[d], 160'({row[d], col[d]}), 160'(0));
        if (expq[d].size() == 0) begin
          check("unexpected_beat", 1'b0, 160'({row[d], col[d]}), 160'(0));
        end else begin
          e = expq[d].pop_front();
          check("beat_pos", int'(row[d]) == e.r && int'(col[d]) == e.c,
                160'({row[d], col[d]}), 160'({2'(e.r), 2'(e.c)}));
          check("beat_data", elem[d] == e.data, 160'(elem[d]), 160'(e.data));
          check("beat_last", last[d] == e.last, 160'(last[d]), 160'(e.last));
          if (e.last) pend_done[d] = 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic cplx_t pat_elem(input int r, input int c);
    cplx_t v;
    v.im = 64'(c);
    v.re = 64'(10 * r + c);
    return v;
  endfunction

  task automatic do_start(input int d);
    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    check("start_busy", busy[d] == 1'b1, 160'(busy[d]), 160'(1));
    check("start_ready", out_ready[d] == 1'b1, 160'(out_ready[d]), 160'(1));
    check("start_err_clr", err[d] == 1'b0, 160'(err[d]), 160'(0));
  endtask

  // mode 0: pattern data, 1: random data, 2: column full of re=99
  task automatic send_col(input int d, input int j, input int mode);
    logic [EW-1:0] v;
    for (int r = 0; r < SZ; r++) begin
      if (mode == 0)      v = pat_elem(r, j);
      else if (mode == 1) v = {$urandom, $urandom, $urandom, $urandom};
      else                v = {64'(j), 64'd99};
      mat[d][j][r] = v;
      col_in[d][r*EW +: EW] = v;
    end
    addr[d]      = 2'(j);
    col_valid[d] = 1'b1;
    step();
    col_valid[d] = 1'b0;
  endtask

  task automatic push_expected(input int d);
    exp_t x;
    for (int r = 0; r < SZ; r++)
      for (int c = (d == 1) ? r : 0; c < SZ; c++) begin
        x.r = r; x.c = c; x.data = mat[d][c][r];
        x.last = (r == SZ - 1) && (c == SZ - 1);
        expq[d].push_back(x);
      end
  endtask

  // rmode 0: ready always 1, 1: pattern 1,0,0,1, 2: random
  task automatic finish_run(input int d, input int rmode, input bit exp_err);
    int b0, dc0;
    bit tog[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    push_expected(d);
    check("first_valid_latency", valid[d] == 1'b1, 160'(valid[d]), 160'(1));
    check("ready_drop", out_ready[d] == 1'b0, 160'(out_ready[d]), 160'(0));
    b0  = beats[d];
    dc0 = done_cnt[d];
    for (int i = 0; i < 200; i++) begin
      if (done_cnt[d] > dc0) break;
      if (rmode == 0)      ready[d] = 1'b1;
      else if (rmode == 1) ready[d] = tog[i % 4];
      else                 ready[d] = 1'($urandom % 2);
      step();
    end
    ready[d] = 1'b1;
    check("run_complete", done_cnt[d] > dc0, 160'(done_cnt[d] - dc0), 160'(1));
    check("beat_count", (beats[d] - b0) == ((d == 1) ? 10 : 16),
          160'(beats[d] - b0), 160'((d == 1) ? 10 : 16));
    check("queue_drained", expq[d].size() == 0, 160'(expq[d].size()), 160'(0));
    check("err_flag", err[d] == exp_err, 160'(err[d]), 160'(exp_err));
    check("idle_after", busy[d] == 1'b0, 160'(busy[d]), 160'(0));
  endtask

  task automatic random_run(input int d, input int rmode);
    int perm[4] = '{0, 1, 2, 3};
    int k, t;
    for (int i = 3; i > 0; i--) begin
      k = $urandom_range(i, 0);
      t = perm[i]; perm[i] = perm[k]; perm[k] = t;
    end
    do_start(d);
    for (int i = 0; i < 4; i++) send_col(d, perm[i], 1);
    finish_run(d, rmode, 1'b0);
  endtask

  initial begin
    int b0;
    int ord[4] = '{3, 1, 0, 2};
    total = 0; bad = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; flush[d] = 1'b0; col_valid[d] = 1'b0;
      ready[d] = 1'b1; col_in[d] = '0; addr[d] = '0;
      beats[d] = 0; done_cnt[d] = 0; pend_done[d] = 0; hold_v[d] = 0;
    end
    #22;
    for (int d = 0; d < 2; d++)
      check("reset_outputs",
            {out_ready[d], valid[d], last[d], done[d], busy[d], err[d], row[d], col[d]} == '0 &&
            elem[d] == '0,
            160'({out_ready[d], valid[d], last[d], done[d], busy[d], err[d], row[d], col[d]}),
            160'(0));
    step();
    rst[0] = 1'b0; rst[1] = 1'b0;
    step();

    // Pattern data, columns 3,1,0,2, ready held high then toggling 1,0,0,1.
    for (int m = 0; m < 2; m++) begin
      do_start(0);
      for (int i = 0; i < 4; i++) send_col(0, ord[i], 0);
      finish_run(0, m, 1'b0);
    end

    // Upper-triangular drain.
    do_start(1);
    for (int i = 0; i < 4; i++) send_col(1, ord[i], 0);
    finish_run(1, 0, 1'b0);
    random_run(1, 1);

    // Duplicate column 2, second copy wins.
    do_start(0);
    send_col(0, 2, 1);
    send_col(0, 2, 2);
    check("dup_err", err[0] == 1'b1, 160'(err[0]), 160'(1));
    send_col(0, 0, 1);
    send_col(0, 1, 1);
    check("dup_no_drain", valid[0] == 1'b0 && out_ready[0] == 1'b1,
          160'({valid[0], out_ready[0]}), 160'(2'b01));
    send_col(0, 3, 1);
    finish_run(0, 0, 1'b1);

    // Flush after two columns, then a full run.
    do_start(0);
    send_col(0, 0, 1);
    send_col(0, 1, 1);
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    check("flush_idle", busy[0] == 1'b0 && out_ready[0] == 1'b0,
          160'({busy[0], out_ready[0]}), 160'(0));
    step();
    random_run(0, 2);

    // Asynchronous reset in the middle of the drain.
    do_start(0);
    for (int i = 0; i < 4; i++) send_col(0, ord[i], 1);
    push_expected(0);
    b0 = beats[0];
    for (int i = 0; i < 60 && (beats[0] - b0) < 5; i++) @(negedge clk);
    #3;
    rst[0] = 1'b1;
    #1;
    check("async_rst", {valid[0], busy[0], out_ready[0]} == 3'b000,
          160'({valid[0], busy[0], out_ready[0]}), 160'(0));
    expq[0].delete();
    step();
    step();
    rst[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_col(0, i, 1);
      check("ignored_after_rst", {out_ready[0], busy[0], valid[0]} == 3'b000,
            160'({out_ready[0], busy[0], valid[0]}), 160'(0));
    end
    random_run(0, 0);

    // Random sweep on both variants.
    for (int i = 0; i < 4; i++) begin
      random_run(0, 2);
      random_run(1, 2);
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
